// File: rtl/tach_speed_meter_if.sv
// Tachometer speed meter signal bundle: measurement control, raw tach input,
// and the latched speed level / strobe / stall outputs.
interface tach_speed_meter_if;
  logic       enable;
  logic       tach_in;
  logic [3:0] counter;
  logic       valid;
  logic       stall;

  modport master (output enable, output tach_in, input counter, input valid, input stall);
  modport slave  (input enable, input tach_in, output counter, output valid, output stall);
endinterface

// File: rtl/tach_speed_meter.sv
// Fan speed meter: synchronise and debounce the tach input, count rising edges
// over a fixed gate window, then publish a saturated 0..15 level plus a stall flag.
module tach_speed_meter #(
  parameter int unsigned GATE_CYCLES     = 1_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned PULSES_PER_STEP = 2
) (
  input  logic               clk,
  input  logic               reset,
  tach_speed_meter_if.slave  bus
);
  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_NEED   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEASURE} state_t;

  state_t        r_state, w_state_next;
  logic          r_sync1, r_sync2, r_prev, r_filt, r_filt_d;
  logic [DW-1:0] r_run, w_run;
  logic          w_rise;
  logic [GW-1:0] r_gate;
  logic [15:0]   r_acc, w_acc_next, w_quot;
  logic [3:0]    r_counter, w_level;
  logic          r_valid, r_stall;
  logic          w_win_end, w_publish;

  // w_run counts how many consecutive samples matched the previous one, so
  // the synced bit has held its value for w_run+1 samples.
  always_comb begin
    w_run = '0;
    if (r_sync2 == r_prev)
      w_run = (r_run == DB_MAX) ? r_run : r_run + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_run    <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
    end else begin
      r_sync1  <= bus.tach_in;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_run    <= w_run;
      if (w_run >= DB_NEED)
        r_filt <= r_sync2;
      r_filt_d <= r_filt;
    end
  end

  assign w_rise     = r_filt & ~r_filt_d;
  assign w_win_end  = (r_gate == GATE_LAST);
  assign w_acc_next = (w_rise && (r_acc != '1)) ? r_acc + 16'd1 : r_acc;
  assign w_quot     = w_acc_next / 16'(PULSES_PER_STEP);
  assign w_level    = (w_quot > 16'd15) ? 4'hF : w_quot[3:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_publish    = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.enable) w_state_next = S_SETTLE;
      S_SETTLE:  if (!bus.enable) w_state_next = S_IDLE;
                 else if (w_win_end) w_state_next = S_MEASURE;
      S_MEASURE: if (!bus.enable) w_state_next = S_IDLE;
                 else if (w_win_end) w_publish = 1'b1;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // An edge landing on the window-end cycle is folded into the closing window
  // via w_acc_next before the accumulator is cleared for the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_gate    <= '0;
      r_acc     <= '0;
      r_counter <= '0;
      r_valid   <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      r_valid <= w_publish;
      if (r_state == S_IDLE || !bus.enable || w_win_end) begin
        r_gate <= '0;
        r_acc  <= '0;
      end else begin
        r_gate <= r_gate + GW'(1);
        r_acc  <= w_acc_next;
      end
      if (w_publish) begin
        r_counter <= w_level;
        r_stall   <= (w_acc_next == '0);
      end
    end
  end

  assign bus.counter = r_counter;
  assign bus.valid   = r_valid;
  assign bus.stall   = r_stall;
endmodule

// File: tb/tb_tach_speed_meter.sv
// Scoreboard bench for tach_speed_meter: two instances (2 and 1 pulses per step)
// share stimulus; monitors pop expected level/stall/strobe-cycle on each valid.
module tb_tach_speed_meter;
  logic        clk, reset, en, tach;
  int unsigned cyc, per, ph;
  bit          glitch;
  int unsigned errors, checks;

  typedef struct {
    logic [3:0]  c;
    logic        s;
    int unsigned at;
  } exp_t;
  exp_t qa[$], qb[$];

  tach_speed_meter_if ifa ();
  tach_speed_meter_if ifb ();
  assign ifa.enable  = en;
  assign ifa.tach_in = tach;
  assign ifb.enable  = en;
  assign ifb.tach_in = tach;

  tach_speed_meter #(.GATE_CYCLES(100), .DEBOUNCE_CYCLES(2), .PULSES_PER_STEP(2))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));
  tach_speed_meter #(.GATE_CYCLES(100), .DEBOUNCE_CYCLES(2), .PULSES_PER_STEP(1))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Tach generator: per/2 high then per/2 low; per==0 holds low; glitch = one high cycle.
  initial begin
    tach = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (glitch) begin
        tach   = 1'b1;
        glitch = 1'b0;
      end else if (per == 0) begin
        tach = 1'b0;
      end else begin
        tach = (ph < per / 2);
        ph   = (ph + 1 >= per) ? 0 : ph + 1;
      end
    end
  end

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifa.valid === 1'b1) begin
        if (qa.size() == 0) check("a_unexpected_valid", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_counter", ifa.counter, e.c);
          check("a_stall", ifa.stall, e.s);
          check("a_valid_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifb.valid === 1'b1) begin
        if (qb.size() == 0) check("b_unexpected_valid", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_counter", ifb.counter, e.c);
          check("b_stall", ifb.stall, e.s);
          check("b_valid_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_counter"}, ifa.counter, 0);
    check({tag, "_a_valid"}, ifa.valid, 0);
    check({tag, "_a_stall"}, ifa.stall, 0);
    check({tag, "_b_counter"}, ifb.counter, 0);
    check({tag, "_b_valid"}, ifb.valid, 0);
    check({tag, "_b_stall"}, ifb.stall, 0);
  endtask

  // Reset for one cycle, verify outputs, then raise enable; n0 is the enable cycle.
  task automatic start_phase(input int unsigned p, output int unsigned n0);
    @(negedge clk);
    reset = 1'b1; en = 1'b0; per = p; ph = 0; glitch = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0; en = 1'b1;
    n0 = cyc;
  endtask

  // k-th measured window strobes 201 + 100*k cycles after enable was raised.
  task automatic expect_windows(input int unsigned n0, input int unsigned nwin,
                                input int unsigned ca, input int unsigned sa,
                                input int unsigned cb, input int unsigned sb);
    for (int unsigned k = 0; k < nwin; k++) begin
      qa.push_back('{c: 4'(ca), s: 1'(sa), at: n0 + 201 + 100 * k});
      qb.push_back('{c: 4'(cb), s: 1'(sb), at: n0 + 201 + 100 * k});
    end
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_a_pending"}, qa.size(), 0);
    check({tag, "_b_pending"}, qb.size(), 0);
  endtask

  task automatic run_phase(input string tag, input int unsigned p, input int unsigned nwin,
                           input int unsigned ca, input int unsigned sa,
                           input int unsigned cb, input int unsigned sb);
    int unsigned n0;
    start_phase(p, n0);
    expect_windows(n0, nwin, ca, sa, cb, sb);
    wait_until(n0 + 201 + 100 * (nwin - 1) + 20);
    drain_check(tag);
  endtask

  initial begin
    int unsigned n0, m;
    errors = 0; checks = 0;
    reset = 1'b1; en = 1'b0; per = 0; ph = 0; glitch = 1'b0;
    repeat (3) @(negedge clk);

    run_phase("p10", 10, 3, 5, 0, 10, 0);
    run_phase("low", 0, 2, 0, 1, 0, 1);
    run_phase("p4", 4, 2, 12, 0, 15, 0);
    run_phase("p2", 2, 2, 0, 1, 0, 1);
    run_phase("p6", 6, 2, 8, 0, 15, 0);

    start_phase(0, n0);
    expect_windows(n0, 2, 0, 1, 0, 1);
    wait_until(n0 + 150);
    glitch = 1'b1;
    wait_until(n0 + 321);
    drain_check("glitch");

    start_phase(10, n0);
    expect_windows(n0, 2, 5, 0, 10, 0);
    wait_until(n0 + 350);
    en = 1'b0;
    wait_until(n0 + 500);
    check("hold_a_counter", ifa.counter, 5);
    check("hold_a_stall", ifa.stall, 0);
    check("hold_b_counter", ifb.counter, 10);
    drain_check("disable");
    en = 1'b1;
    m  = cyc;
    expect_windows(m, 1, 5, 0, 10, 0);
    wait_until(m + 250);
    drain_check("reenable");
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    reset = 1'b0; en = 1'b0;
    repeat (20) @(negedge clk);
    drain_check("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
